// File: rtl/spi_slave_rx_deser_if.sv
// Valid/ready word stream from the SPI receive front-end to the command decoder.
interface spi_slave_rx_deser_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] m_data_o;
    logic              m_valid_o;
    logic              m_ready_i;

    modport master (
        output m_data_o,
        output m_valid_o,
        input  m_ready_i
    );

    modport slave (
        input  m_data_o,
        input  m_valid_o,
        output m_ready_i
    );
endinterface

// File: rtl/spi_slave_rx_deser.sv
// SPI slave receive front-end: oversamples pad-level SPI, deserialises std/quad MSB-first
// traffic into DATA_W-bit words and queues them in a small valid/ready FIFO.
module spi_slave_rx_deser #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        spi_sclk_i,
    input  logic                        spi_csn_i,
    input  logic [3:0]                  spi_sdi_i,
    input  logic                        quad_en_i,
    input  logic                        clear_i,
    spi_slave_rx_deser_if.master        m_if,
    output logic                        frame_start_o,
    output logic                        frame_end_o,
    output logic                        overflow_o,
    output logic                        partial_o
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [3:0]             sdi_sync [SYNC_STAGES];
    logic                   sclk_hist;
    logic                   csn_hist;
    logic [3:0]             sdi_hist;
    logic [SYNC_STAGES:0]   warm;

    logic                   sclk_s;
    logic                   csn_s;
    logic                   warm_done;
    logic                   sclk_rise;
    logic                   csn_rise;
    logic                   csn_fall;

    logic [0:0]             state;
    logic                   quad;
    logic                   armed;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nx;
    logic [DATA_W-1:0]      sh;
    logic                   wr_pend;
    logic                   start_evt;
    logic                   partial_set;

    logic [DATA_W-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]          wp;
    logic [AW-1:0]          rp;
    logic [AW:0]            count;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   overflow_set;

    // Synchronisers plus one history stage; warm tracks when history holds real pad samples.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync <= '0;
            csn_sync  <= '1;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sdi_sync[i] <= '0;
            end
            sclk_hist <= 1'b0;
            csn_hist  <= 1'b1;
            sdi_hist  <= '0;
            warm      <= '0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
            csn_sync    <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
            sdi_sync[0] <= spi_sdi_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sdi_sync[i] <= sdi_sync[i-1];
            end
            sclk_hist <= sclk_s;
            csn_hist  <= csn_s;
            sdi_hist  <= sdi_sync[SYNC_STAGES-1];
            warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign warm_done = warm[SYNC_STAGES];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign csn_rise  = csn_s & ~csn_hist;
    assign csn_fall  = ~csn_s & csn_hist;

    // A frame may only start once csn has genuinely been seen high since reset.
    assign start_evt     = (state == IDLE) && armed && csn_fall;
    assign partial_set   = (state == ACTIVE) && csn_rise && (cnt != '0);
    assign frame_start_o = start_evt;
    assign frame_end_o   = (state == ACTIVE) && csn_rise;

    assign cnt_nx = cnt + (quad ? CW'(4) : CW'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            quad      <= 1'b0;
            armed     <= 1'b0;
            cnt       <= '0;
            sh        <= '0;
            wr_pend   <= 1'b0;
            partial_o <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            if (warm_done && csn_s && csn_hist) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start_evt) begin
                        state <= ACTIVE;
                        quad  <= quad_en_i;
                    end
                end
                ACTIVE: begin
                    if (csn_rise) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (sclk_rise) begin
                        sh <= quad ? {sh[DATA_W-5:0], sdi_hist}
                                   : {sh[DATA_W-2:0], sdi_hist[0]};
                        if (cnt_nx == CW'(DATA_W)) begin
                            cnt     <= '0;
                            wr_pend <= 1'b1;
                        end else begin
                            cnt <= cnt_nx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (partial_set) begin
                partial_o <= 1'b1;
            end else if (clear_i) begin
                partial_o <= 1'b0;
            end
        end
    end

    assign full         = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop          = m_if.m_valid_o && m_if.m_ready_i;
    assign push         = wr_pend && (!full || pop);
    assign overflow_set = wr_pend && full && !pop;

    // When full with a same-cycle pop, wp equals rp: the popped slot is reused for the new word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wp         <= '0;
            rp         <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                mem[wp] <= sh;
                wp      <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (overflow_set) begin
                overflow_o <= 1'b1;
            end else if (clear_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

    assign m_if.m_data_o  = mem[rp];
    assign m_if.m_valid_o = (count != '0);

endmodule

// File: tb/tb_spi_slave_rx_deser.sv
// Scoreboard bench for spi_slave_rx_deser: directed SPI frames push expected words,
// a negedge monitor pops and compares every accepted output beat.
module tb_spi_slave_rx_deser;

    logic        clk;
    logic        rst_n;
    logic        sclk;
    logic        csn;
    logic [3:0]  sdi;
    logic        quad_en;
    logic        clear;
    logic        frame_start;
    logic        frame_end;
    logic        overflow;
    logic        partial;

    int          compared;
    int          mismatched;
    int          n_start;
    int          n_end;
    logic [31:0] exp_q [$];

    spi_slave_rx_deser_if #(.DATA_W(32)) m_if ();

    spi_slave_rx_deser #(
        .DATA_W      (32),
        .SYNC_STAGES (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .spi_sclk_i    (sclk),
        .spi_csn_i     (csn),
        .spi_sdi_i     (sdi),
        .quad_en_i     (quad_en),
        .clear_i       (clear),
        .m_if          (m_if),
        .frame_start_o (frame_start),
        .frame_end_o   (frame_end),
        .overflow_o    (overflow),
        .partial_o     (partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && m_if.m_valid_o && m_if.m_ready_i) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL beat: unexpected word 0x%08h, none expected", m_if.m_data_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (m_if.m_data_o !== e) begin
                    mismatched++;
                    $display("FAIL beat: got 0x%08h, expected 0x%08h", m_if.m_data_o, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (frame_start) n_start++;
        if (frame_end)   n_end++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_std(input logic [31:0] v, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            sdi = {3'b000, v[i]};
            tick(6);
            sclk = 1'b1;
            tick(6);
            sclk = 1'b0;
        end
    endtask

    task automatic send_quad(input logic [31:0] v);
        for (int i = 7; i >= 0; i--) begin
            sdi = v[i*4 +: 4];
            tick(6);
            sclk = 1'b1;
            tick(6);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low(input logic q);
        quad_en = q;
        csn = 1'b0;
        tick(8);
    endtask

    task automatic cs_high();
        tick(6);
        csn = 1'b1;
        tick(10);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        n_start     = 0;
        n_end       = 0;
        rst_n       = 1'b0;
        sclk        = 1'b0;
        csn         = 1'b1;
        sdi         = 4'h0;
        quad_en     = 1'b0;
        clear       = 1'b0;
        m_if.m_ready_i = 1'b1;
        tick(3);
        check("reset_valid", {31'd0, m_if.m_valid_o}, 32'd0);
        check("reset_data", m_if.m_data_o, 32'd0);
        check("reset_flags", {28'd0, frame_start, frame_end, overflow, partial}, 32'd0);
        rst_n = 1'b1;
        tick(10);

        // Std single word
        n_start = 0;
        n_end   = 0;
        exp_q.push_back(32'hDEADBEEF);
        cs_low(1'b0);
        send_std(32'hDEADBEEF, 31, 0);
        cs_high();
        check("std_start_pulses", n_start, 1);
        check("std_end_pulses", n_end, 1);
        check("std_drained", exp_q.size(), 0);

        // Quad two words in one frame
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'h9ABCDEF0);
        cs_low(1'b1);
        send_quad(32'h12345678);
        send_quad(32'h9ABCDEF0);
        quad_en = 1'b0;
        cs_high();
        check("quad_partial", {31'd0, partial}, 32'd0);
        check("quad_drained", exp_q.size(), 0);

        // 12-bit partial frame
        cs_low(1'b0);
        send_std(32'h00000ABC, 11, 0);
        cs_high();
        check("partial_set", {31'd0, partial}, 32'd1);
        pulse_clear();
        check("partial_clear", {31'd0, partial}, 32'd0);

        // Overflow: five words, no ready
        m_if.m_ready_i = 1'b0;
        exp_q.push_back(32'h11111111);
        exp_q.push_back(32'h22222222);
        exp_q.push_back(32'h33333333);
        exp_q.push_back(32'h44444444);
        cs_low(1'b0);
        send_std(32'h11111111, 31, 0);
        send_std(32'h22222222, 31, 0);
        send_std(32'h33333333, 31, 0);
        send_std(32'h44444444, 31, 0);
        send_std(32'h55555555, 31, 0);
        cs_high();
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_valid", {31'd0, m_if.m_valid_o}, 32'd1);
        check("ovf_head", m_if.m_data_o, 32'h11111111);
        m_if.m_ready_i = 1'b1;
        tick(10);
        check("ovf_drained", exp_q.size(), 0);
        pulse_clear();
        check("ovf_clear", {31'd0, overflow}, 32'd0);

        // Full FIFO, fifth word lands in the same cycle as a pop
        m_if.m_ready_i = 1'b0;
        exp_q.push_back(32'hA0000001);
        exp_q.push_back(32'hB0000002);
        exp_q.push_back(32'hC0000003);
        exp_q.push_back(32'hD0000004);
        exp_q.push_back(32'hE0000005);
        cs_low(1'b0);
        send_std(32'hA0000001, 31, 0);
        send_std(32'hB0000002, 31, 0);
        send_std(32'hC0000003, 31, 0);
        send_std(32'hD0000004, 31, 0);
        send_std(32'hE0000005, 31, 1);
        sdi = 4'h1;
        tick(6);
        sclk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_if.m_ready_i = 1'b1;
        @(posedge clk);
        #1;
        m_if.m_ready_i = 1'b0;
        tick(5);
        sclk = 1'b0;
        cs_high();
        check("sim_pop_no_ovf", {31'd0, overflow}, 32'd0);
        check("sim_pop_remaining", exp_q.size(), 4);
        m_if.m_ready_i = 1'b1;
        tick(10);
        check("sim_pop_drained", exp_q.size(), 0);

        // Reset mid-frame with a word still queued
        m_if.m_ready_i = 1'b0;
        cs_low(1'b0);
        send_std(32'h0F0F0F0F, 31, 0);
        cs_high();
        cs_low(1'b0);
        send_std(32'hFFFF0000, 31, 22);
        check("pre_rst_valid", {31'd0, m_if.m_valid_o}, 32'd1);
        check("pre_rst_data", m_if.m_data_o, 32'h0F0F0F0F);
        rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, m_if.m_valid_o}, 32'd0);
        check("rst_data", m_if.m_data_o, 32'd0);
        check("rst_flags", {30'd0, overflow, partial}, 32'd0);
        tick(3);
        rst_n = 1'b1;
        m_if.m_ready_i = 1'b1;
        send_std(32'hFFFF0000, 21, 0);
        cs_high();
        check("post_rst_no_word", {31'd0, m_if.m_valid_o}, 32'd0);
        check("post_rst_partial", {31'd0, partial}, 32'd0);
        exp_q.push_back(32'hA5A5A5A5);
        cs_low(1'b0);
        send_std(32'hA5A5A5A5, 31, 0);
        cs_high();
        tick(10);
        check("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
